// File: rtl/sim_data_bus_router.sv
// Routes one core data port onto N_TGT OBI-like targets by base/mask decode, keeps
// an in-order FIFO of target ids so each response comes from the right target.
module sim_data_bus_router #(
   parameter int                       N_TGT     = 3,
   parameter int                       ADDR_W    = 32,
   parameter int                       DATA_W    = 32,
   parameter int                       MAX_OUTST = 2,
   parameter logic [N_TGT*ADDR_W-1:0]  TGT_BASE  = '0,
   parameter logic [N_TGT*ADDR_W-1:0]  TGT_MASK  = '0,
   parameter logic [ADDR_W-1:0]        EXIT_ADDR = ADDR_W'(32'h8000_0000)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                m_req_i,
   output logic                                m_gnt_o,
   input  logic [ADDR_W-1:0]                   m_addr_i,
   input  logic                                m_we_i,
   input  logic [DATA_W/8-1:0]                 m_be_i,
   input  logic [DATA_W-1:0]                   m_wdata_i,
   output logic [DATA_W-1:0]                   m_rdata_o,
   output logic                                m_rvalid_o,
   output logic                                m_err_o,
   output logic [N_TGT-1:0]                    tgt_req_o,
   output logic [ADDR_W-1:0]                   tgt_addr_o,
   output logic                                tgt_we_o,
   output logic [DATA_W/8-1:0]                 tgt_be_o,
   output logic [DATA_W-1:0]                   tgt_wdata_o,
   input  logic [N_TGT-1:0]                    tgt_gnt_i,
   input  logic [N_TGT-1:0]                    tgt_rvalid_i,
   input  logic [N_TGT*DATA_W-1:0]             tgt_rdata_i,
   output logic [DATA_W-1:0]                   exit_code_o,
   output logic                                exit_valid_o,
   output logic                                proto_err_o,
   output logic [$clog2(MAX_OUTST+1)-1:0]      outstanding_o
);

   localparam int ID_W  = $clog2(N_TGT + 2);
   localparam int CNT_W = $clog2(MAX_OUTST + 1);
   localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int BE_W  = DATA_W / 8;
   localparam logic [ID_W-1:0] ID_EXIT = ID_W'(N_TGT);
   localparam logic [ID_W-1:0] ID_ERR  = ID_W'(N_TGT + 1);

   logic [ID_W-1:0]  sel;
   logic [ID_W-1:0]  head;
   logic [ID_W-1:0]  fifo_q [MAX_OUTST];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             full, empty, push, pop;
   logic             sel_gnt;
   logic [N_TGT-1:0] rv_expected;
   logic             proto_hit;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (MAX_OUTST == 1) return '0;
      return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full          = (cnt_q == CNT_W'(MAX_OUTST));
   assign empty         = (cnt_q == '0);
   assign push          = m_req_i & m_gnt_o;
   assign pop           = m_rvalid_o;
   assign outstanding_o = cnt_q;
   assign head          = fifo_q[rd_ptr_q];

   assign tgt_addr_o  = m_addr_i;
   assign tgt_we_o    = m_we_i;
   assign tgt_be_o    = m_be_i;
   assign tgt_wdata_o = m_wdata_i;

   // Descending scan so the lowest-index matching region ends up selected.
   always_comb begin
      sel = ID_ERR;
      for (int i = N_TGT - 1; i >= 0; i--) begin
         if ((m_addr_i & TGT_MASK[i*ADDR_W +: ADDR_W]) == TGT_BASE[i*ADDR_W +: ADDR_W])
            sel = ID_W'(i);
      end
      if (m_addr_i == EXIT_ADDR) sel = ID_EXIT;
   end

   always_comb begin
      sel_gnt   = 1'b1;
      tgt_req_o = '0;
      for (int i = 0; i < N_TGT; i++) begin
         if (sel == ID_W'(i)) begin
            sel_gnt      = tgt_gnt_i[i];
            tgt_req_o[i] = m_req_i & ~full;
         end
      end
      m_gnt_o = m_req_i & ~full & sel_gnt;
   end

   always_comb begin
      m_rvalid_o  = 1'b0;
      m_rdata_o   = '0;
      m_err_o     = 1'b0;
      rv_expected = '0;
      if (!empty) begin
         if (head == ID_EXIT) begin
            m_rvalid_o = 1'b1;
            m_rdata_o  = exit_code_o;
         end else if (head == ID_ERR) begin
            m_rvalid_o = 1'b1;
            m_err_o    = 1'b1;
         end else begin
            for (int i = 0; i < N_TGT; i++) begin
               if (head == ID_W'(i)) begin
                  rv_expected[i] = 1'b1;
                  m_rvalid_o     = tgt_rvalid_i[i];
                  if (tgt_rvalid_i[i]) m_rdata_o = tgt_rdata_i[i*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   // Any rvalid from a target that is not the FIFO head is a stray response.
   assign proto_hit = |(tgt_rvalid_i & ~rv_expected);

   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q] <= sel;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         exit_code_o  <= '0;
         exit_valid_o <= 1'b0;
         proto_err_o  <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push && !pop)      cnt_q <= cnt_q + 1'b1;
         else if (!push && pop) cnt_q <= cnt_q - 1'b1;
         if (push && sel == ID_EXIT && m_we_i) begin
            exit_valid_o <= 1'b1;
            for (int b = 0; b < BE_W; b++) begin
               if (m_be_i[b]) exit_code_o[b*8 +: 8] <= m_wdata_i[b*8 +: 8];
            end
         end
         if (proto_hit) proto_err_o <= 1'b1;
      end
   end

endmodule

// File: doc/sim_data_bus_router.md
Name: sim_data_bus_router

Overview:
- Parametrised data-bus router for the HWPE simulation top; successor to the fixed three-way periph/stack/TCDM split.
- Decodes one core data port onto N_TGT OBI-like target ports via base/mask regions.
- Tracks outstanding transactions in order, so responses come back from the correct target rather than an OR of all rvalids.
- Provides an internal decode-error responder and an internal exit mailbox that captures the program's return code.

Parameters:
- N_TGT, 3, number of external targets (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8).
- MAX_OUTST, 2, outstanding-transaction FIFO depth (power of 2, >=1).
- TGT_BASE, {N_TGT{ADDR_W'0}}, packed per-target region base.
- TGT_MASK, {N_TGT{ADDR_W'0}}, packed per-target mask; a target matches when (addr & mask) == base.
- EXIT_ADDR, 32'h8000_0000, address of the internal exit mailbox.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- m_req_i  in  1  master request
- m_gnt_o  out  1  master grant
- m_addr_i  in  ADDR_W  master address
- m_we_i  in  1  write enable (1 = write)
- m_be_i  in  DATA_W/8  byte enables
- m_wdata_i  in  DATA_W  write data
- m_rdata_o  out  DATA_W  response data
- m_rvalid_o  out  1  response valid
- m_err_o  out  1  response error, qualified by m_rvalid_o
- tgt_req_o  out  N_TGT  per-target request
- tgt_addr_o  out  ADDR_W  shared address (= m_addr_i)
- tgt_we_o  out  1  shared write enable
- tgt_be_o  out  DATA_W/8  shared byte enables
- tgt_wdata_o  out  DATA_W  shared write data
- tgt_gnt_i  in  N_TGT  per-target grant
- tgt_rvalid_i  in  N_TGT  per-target response valid
- tgt_rdata_i  in  N_TGT*DATA_W  packed per-target response data
- exit_code_o  out  DATA_W  last value written to EXIT_ADDR
- exit_valid_o  out  1  sticky; set on the first exit write
- proto_err_o  out  1  sticky protocol-violation flag
- outstanding_o  out  $clog2(MAX_OUTST+1)  current FIFO occupancy

Behaviour:
- Decode (combinational):
  - addr == EXIT_ADDR -> EXIT.
  - Otherwise the lowest-index matching target wins.
  - Otherwise ERR.
  - Internal id width = $clog2(N_TGT+2); EXIT = N_TGT, ERR = N_TGT+1.
- Request path, zero latency:
  - tgt_req_o[i] = m_req_i & sel==i & ~full.
  - m_gnt_o = ~full & (sel<N_TGT ? tgt_gnt_i[sel] : 1).
  - While full: no tgt_req_o asserted and m_gnt_o=0, even if a pop occurs in the same cycle.
- Handshake (m_req_i & m_gnt_o): push sel into the FIFO. An EXIT write updates exit_code_o with m_wdata_i masked by m_be_i bytes (unselected bytes keep their old value) and sets exit_valid_o, both visible the next cycle.
- Response path, head = FIFO head id, only when the FIFO is non-empty:
  - Head < N_TGT: m_rvalid_o = tgt_rvalid_i[head], m_rdata_o = that target's slice, m_err_o = 0.
  - Head == EXIT: m_rvalid_o = 1, m_rdata_o = exit_code_o, m_err_o = 0.
  - Head == ERR: m_rvalid_o = 1, m_rdata_o = 0, m_err_o = 1.
  - Internal responders therefore answer >=1 cycle after grant (FIFO is registered).
  - Pop when m_rvalid_o = 1.
- Simultaneous push and pop when not full: occupancy is unchanged; pointers wrap modulo MAX_OUTST.
- Protocol error: any tgt_rvalid_i[j] with FIFO empty or j != head sets proto_err_o; that response is dropped and not forwarded.
- Idle outputs: m_rdata_o = 0 whenever m_rvalid_o = 0.
- Reset:
  - FIFO empty, outstanding_o = 0, exit_code_o = 0, exit_valid_o = 0, proto_err_o = 0, m_rvalid_o = 0, m_gnt_o follows decode (0 when m_req_i = 0), tgt_req_o = 0.
  - Reset mid-operation discards in-flight ids; targets must be reset together with the router.

Test Plan:
- Regions T0 = 0x0000_0000/0xFF00_0000 and T1 = 0x1000_0000/0xFF00_0000. Read 0x1000_0040 with T1 returning 0xDEADBEEF two cycles after gnt -> m_rvalid_o = 1 with m_rdata_o = 0xDEADBEEF, m_err_o = 0, outstanding_o 1->0.
- Back-to-back reads T0 then T1; T1 holds tgt_rvalid early (before T0 responds) -> proto_err_o = 1, T1 data dropped; T0 response still forwarded.
- MAX_OUTST = 2, two granted reads with no responses, third request -> m_gnt_o = 0 and tgt_req_o = 0 until a response pops.
- Access to 0x5000_0000 (unmapped) -> m_gnt_o = 1 same cycle; the next cycle m_rvalid_o = 1, m_err_o = 1, m_rdata_o = 0.
- Write 0x0000_0003 to EXIT_ADDR with be = 4'b0001, then read EXIT_ADDR -> exit_valid_o = 1, exit_code_o = 0x0000_0003, read returns 0x0000_0003.
- Assert rst_i with 2 transactions outstanding -> next cycle outstanding_o = 0 and all sticky flags cleared.
